// File: rtl/fifo_2regs_arbiter_if.sv
// Bundle of the requester-side and consumer-side handshakes of
// fifo_2regs_arbiter.
//   req_valid/req_data/req_ready : NUM_REQ requesters, word i in req_data[i*WIDTH +: WIDTH]
//   out_valid/out_ready/out_data : single consumer stream
//   out_src                      : requester index of the head word
//   occupancy                    : entries held, 0..2
// slave  = arbiter side, master = requesters + consumer side.
interface fifo_2regs_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
);
  localparam int SRC_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [SRC_BITS-1:0]      out_src;
  logic [1:0]               occupancy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, occupancy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, occupancy
  );
endinterface

// File: rtl/fifo_2regs_arbiter.sv
// Round-robin arbiter feeding a two-register FIFO (head/tail), each entry
// tagged with the index of the requester that supplied it.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   srst  : synchronous clear, active high
//   bus   : fifo_2regs_arbiter_if.slave (requester and consumer handshakes)
// Grant search starts at ptr and wraps; ptr advances past each winner.
// A push into a full buffer is allowed in the same cycle as a pop.
module fifo_2regs_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 srst,
  fifo_2regs_arbiter_if.slave  bus
);
  localparam int SRC_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int ENTRY_W  = WIDTH + SRC_BITS;
  localparam int unsigned NR = NUM_REQ;

  logic [1:0]          occ_q;
  logic [SRC_BITS-1:0] ptr_q;
  logic [ENTRY_W-1:0]  head_q;
  logic [ENTRY_W-1:0]  tail_q;

  logic                pop;
  logic                push;
  logic                space;
  logic                found;
  logic [SRC_BITS-1:0] winner;
  logic [SRC_BITS-1:0] next_ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [WIDTH-1:0]    win_data;
  logic [ENTRY_W-1:0]  new_entry;

  assign pop   = (occ_q != 2'd0) && bus.out_ready;
  assign space = (occ_q != 2'd2) || pop;
  assign push  = |grant;

  // Rotating priority search: first valid requester at or after ptr.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      int unsigned idx;
      logic [SRC_BITS-1:0] sel;
      idx = 32'(ptr_q) + k;
      if (idx >= NR) idx = idx - NR;
      sel = SRC_BITS'(idx);
      if (!found && bus.req_valid[sel]) begin
        found  = 1'b1;
        winner = sel;
      end
    end
  end

  // Grants are suppressed during either reset so nothing is lost.
  always_comb begin
    grant = '0;
    if (found && space && rst_n && !srst) grant[winner] = 1'b1;
  end

  always_comb begin
    win_data = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (SRC_BITS'(k) == winner) win_data = bus.req_data[k*WIDTH +: WIDTH];
    end
  end

  assign next_ptr  = (winner == SRC_BITS'(NR - 1)) ? '0 : winner + 1'b1;
  assign new_entry = {winner, win_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      ptr_q <= '0;
    end else if (srst) begin
      occ_q <= '0;
      ptr_q <= '0;
    end else begin
      if (push) ptr_q <= next_ptr;
      if (push && !pop)      occ_q <= occ_q + 2'd1;
      else if (pop && !push) occ_q <= occ_q - 2'd1;
    end
  end

  // Payload registers are not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push && (occ_q == 2'd0 || (occ_q == 2'd1 && pop))) begin
      head_q <= new_entry;
    end else if (push && occ_q == 2'd1) begin
      tail_q <= new_entry;
    end else if (push && occ_q == 2'd2) begin
      head_q <= tail_q;
      tail_q <= new_entry;
    end else if (pop && occ_q == 2'd2) begin
      head_q <= tail_q;
    end
  end

  assign bus.req_ready = grant;
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = head_q[WIDTH-1:0];
  assign bus.out_src   = head_q[ENTRY_W-1:WIDTH];
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_fifo_2regs_arbiter.sv
// Scoreboard bench for fifo_2regs_arbiter (NUM_REQ=4, WIDTH=16).
// Stimulus drives directed phases and pushes the hand-derived expected
// {src, data} words; a monitor pops and compares on every consumer pop.
module tb_fifo_2regs_arbiter;
  localparam int NR = 4;
  localparam int W  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic srst  = 1'b0;

  fifo_2regs_arbiter_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

  fifo_2regs_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (srst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [17:0] exp_q[$];
  int cnt[NR];
  int left[NR];
  int exp_cnt[NR];

  // Word c of requester i; requester 1 word 0 is 0x1234.
  function automatic logic [15:0] wdata(input int i, input int c);
    return 16'(32'h1000 * i + 32'h0234 + c);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]        = (left[i] != 0);
      bus.req_data[i*W +: W]  = wdata(i, cnt[i]);
    end
  endtask

  // One cycle: check grant/occupancy at the negedge, record expected words
  // for the grants we expect, then update requesters after the posedge.
  task automatic step(input logic [3:0] er, input int eo, input string nm);
    logic [3:0] acc;
    @(negedge clk);
    chk({nm, " req_ready"}, 32'(bus.req_ready), 32'(er));
    chk({nm, " occupancy"}, 32'(bus.occupancy), 32'(eo));
    chk({nm, " out_valid"}, 32'(bus.out_valid), 32'(eo != 0));
    for (int i = 0; i < NR; i++) begin
      if (er[i]) begin
        exp_q.push_back({2'(i), wdata(i, exp_cnt[i])});
        exp_cnt[i]++;
      end
    end
    acc = bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        cnt[i]++;
        left[i]--;
      end
    end
    drive();
  endtask

  always @(negedge clk) begin : monitor
    logic [17:0] e;
    if (rst_n && !srst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_pop: got %h expected no word", {bus.out_src, bus.out_data});
      end else begin
        e = exp_q.pop_front();
        chk("pop src_data", 32'({bus.out_src, bus.out_data}), 32'(e));
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      cnt[i]     = 0;
      exp_cnt[i] = 0;
      left[i]    = 1;
    end
    bus.out_ready = 1'b0;
    drive();

    // Reset with all requesters valid: no grant may leak out.
    repeat (3) step(4'b0000, 0, "reset");
    for (int i = 0; i < NR; i++) left[i] = 0;
    drive();
    rst_n = 1'b1;
    repeat (3) step(4'b0000, 0, "idle");

    // Single source, one-cycle latency.
    left[1] = 1;
    bus.out_ready = 1'b1;
    drive();
    step(4'b0010, 0, "single_acc");
    step(4'b0000, 1, "single_out");
    step(4'b0000, 0, "single_empty");

    // srst while idle brings ptr (now 2) back to 0.
    srst = 1'b1;
    step(4'b0000, 0, "srst_idle");
    srst = 1'b0;

    // Round robin at full throughput.
    for (int i = 0; i < NR; i++) left[i] = 2;
    drive();
    for (int k = 0; k < 8; k++) step(4'(1 << (k % 4)), (k == 0) ? 0 : 1, "rr");
    step(4'b0000, 1, "rr_tail");
    step(4'b0000, 0, "rr_empty");

    // Backpressure fills to 2, then pops with same-cycle pushes.
    bus.out_ready = 1'b0;
    for (int i = 0; i < NR; i++) left[i] = 3;
    drive();
    step(4'b0001, 0, "bp_acc0");
    step(4'b0010, 1, "bp_acc1");
    step(4'b0000, 2, "bp_full");
    step(4'b0000, 2, "bp_full");
    bus.out_ready = 1'b1;
    step(4'b0100, 2, "bp_pop_push");
    step(4'b1000, 2, "full_push_pop");
    step(4'b0001, 2, "full_push_pop");
    bus.out_ready = 1'b0;
    step(4'b0000, 2, "hold_full");

    // srst with buffer full and ptr at 1: contents discarded, grant restarts at 0.
    srst = 1'b1;
    exp_q.delete();
    step(4'b0000, 2, "srst_assert");
    srst = 1'b0;
    bus.out_ready = 1'b1;
    step(4'b0001, 0, "srst_regrant");
    step(4'b0010, 1, "post_srst");
    step(4'b0100, 1, "post_srst");
    step(4'b1000, 1, "post_srst");
    step(4'b0010, 1, "post_srst");
    step(4'b0100, 1, "post_srst");
    step(4'b1000, 1, "post_srst");
    step(4'b0000, 1, "final_tail");
    step(4'b0000, 0, "final_empty");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_2regs_arbiter.md
# fifo_2regs_arbiter

Round-robin arbiter that shares one two-entry register FIFO between NUM_REQ command requesters and presents a single valid/ready stream to the consumer. It owns all write/read sequencing of the two-register buffer, tracks occupancy so the buffer can never overflow or underflow, and tags every entry with the index of the requester that supplied it. It sits between several command sources (e.g. per-channel sequencers) and one shared command sink.

## Interface
- NUM_REQ, 4: number of requesters, 2..16.
- WIDTH, 16: payload width per requester.
- SRC_BITS, derived: max(1, clog2(NUM_REQ)); not user-set.

- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- srst  input  1  synchronous clear, active high; same effect as reset, one cycle.
- req_valid  input  NUM_REQ  bit i: requester i has a word.
- req_data  input  NUM_REQ*WIDTH  requester i word in bits [i*WIDTH +: WIDTH].
- req_ready  output  NUM_REQ  one-hot (or zero) acceptance; bit i high = word i taken this cycle.
- out_valid  output  1  buffer head valid.
- out_ready  input  1  consumer takes head this cycle.
- out_data  output  WIDTH  head payload.
- out_src  output  SRC_BITS  requester index of head.
- occupancy  output  2  entries held, 0..2.

## Operation
- Internal storage: two registers (head, tail) of WIDTH+SRC_BITS, written/read with two-register FIFO semantics; occupancy counter 0..2.
- pop = out_valid && out_ready. out_valid = (occupancy != 0).
- space = (occupancy < 2) || pop (push into full buffer permitted in the same cycle as a pop).
- Grant: search starting at pointer ptr, ascending with wrap at NUM_REQ-1 -> 0; first i with req_valid[i] wins. req_ready[i] = space && winner==i. At most one bit set; all zero if no valid or no space.
- push = |req_ready. On push: ptr <= winner+1 (wrapping NUM_REQ-1 -> 0). No push: ptr holds.
- Occupancy: push&&!pop +1; pop&&!push -1; both or neither: hold.
- Data routing: push into empty buffer, or push with pop when occupancy==1 -> new word becomes head. Push with occupancy==1 and no pop -> tail. Push with pop at occupancy==2 -> tail moves to head, new word to tail. Pop alone at occupancy==2 -> tail moves to head.
- Requester protocol: req_valid and req_data held stable until req_ready; a requester may drop valid only after acceptance. Consumer: out_data/out_src stable while out_valid && !out_ready.
- srst: occupancy <= 0, ptr <= 0; takes priority over push/pop in that cycle; req_ready forced 0 while srst high.

## Timing
- Reset (rst_n low or srst): occupancy 0, out_valid 0, ptr 0, req_ready all 0 (forced 0 while rst_n low), out_data/out_src undefined (not reset).
- Latency: word accepted in cycle N appears at out_data/out_valid in cycle N+1 if buffer was empty (or emptying).
- Throughput: one word per cycle sustained with out_ready held high.
- Combinational paths: req_valid -> req_ready, out_ready -> req_ready (via space). No path from req_data to any output except through registers.
- Reset mid-operation: contents discarded, no partial word reported afterwards.
- Fairness: any continuously valid requester is granted within NUM_REQ pushes.

## Test plan
- Reset then idle: rst_n low 3 cycles, release, no valid -> out_valid 0, occupancy 0, req_ready 0000 every cycle.
- Single source: req_valid=0010, data 0x1234, out_ready=1 -> req_ready=0010 cycle N, out_valid=1, out_data=0x1234, out_src=1 cycle N+1.
- Round robin: all 4 valid continuously, out_ready=1 -> grant order 0,1,2,3,0,1...; out_src sequence matches, one word per cycle.
- Backpressure: out_ready=0, all valid -> exactly 2 accepts (src 0,1), occupancy 2, req_ready 0000 thereafter; raise out_ready -> head 0 then 1 delivered, src 2 accepted in the same cycle as first pop.
- Full with simultaneous push/pop: occupancy 2, out_ready=1, req_valid=1000 -> pop and push same cycle, occupancy stays 2, order preserved.
- srst mid-stream: occupancy 2, assert srst 1 cycle -> next cycle occupancy 0, out_valid 0, next grant starts from requester 0.
